// File: rtl/serializer8_pkg.sv
// Shared types and constants for the 8-bit parallel-to-serial stage.
package serializer8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int             WORD_W   = 8;
  localparam int             SEL_W    = 3;
  localparam logic [SEL_W-1:0] LAST_IDX = 3'd7;

  // Beat count to bit position; MSB-first walks the word downwards.
  function automatic logic [SEL_W-1:0] map_idx(input logic msb_first,
                                               input logic [SEL_W-1:0] cnt);
    return msb_first ? (LAST_IDX - cnt) : cnt;
  endfunction

endpackage

// File: rtl/serializer8_if.sv
// Parallel-in / serial-out handshake bundle for serializer8.
interface serializer8_if;
  import serializer8_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_last;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_last, sel, busy
  );

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_last, sel, busy
  );

endinterface

// File: rtl/serializer8_bit_pick8.sv
// Combinational 8:1 bit select driving the serial line.
module bit_pick8
  import serializer8_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              picked
);

  assign picked = data[sel];

endmodule

// File: rtl/serializer8.sv
// Holds an accepted 8-bit word and emits it one bit per accepted serial beat.
module serializer8
  import serializer8_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
)
(
  input  logic         clk,
  input  logic         reset,
  serializer8_if.slave bus
);

  state_t            state, state_next;
  logic [WORD_W-1:0] data_q, data_next;
  logic [SEL_W-1:0]  cnt, cnt_next;
  logic              in_ready_c;
  logic              shifting;
  logic [SEL_W-1:0]  idx;
  logic              picked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_next;
      data_q <= data_next;
      cnt    <= cnt_next;
    end
  end

  // A word may be loaded from IDLE or on the final beat of the current word,
  // which keeps back-to-back words free of bubbles.
  always_comb begin
    state_next = state;
    data_next  = data_q;
    cnt_next   = cnt;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          data_next  = bus.in_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          if (cnt == LAST_IDX) begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
              data_next = bus.in_data;
              cnt_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign shifting = (state == SHIFT);
  assign idx      = shifting ? map_idx(MSB_FIRST, cnt) : '0;

  bit_pick8 u_pick (
    .data   (data_q),
    .sel    (idx),
    .picked (picked)
  );

  // in_ready is held low for the whole time reset is asserted.
  assign bus.in_ready  = in_ready_c & ~reset;
  assign bus.ser_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.ser_last  = shifting && (cnt == LAST_IDX);
  assign bus.sel       = idx;
  assign bus.ser_out   = shifting ? picked : IDLE_LEVEL;

endmodule

// File: tb/tb_serializer8.sv
// Scoreboard bench: two instances (LSB-first idle-high, MSB-first idle-low).
module tb_serializer8;
  import serializer8_pkg::*;

  typedef struct packed {
    logic       b;
    logic [2:0] sel;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][7:0] in_data;
  logic [1:0]      in_valid;
  logic [1:0]      ser_ready;
  logic [1:0]      in_ready;
  logic [1:0]      ser_out;
  logic [1:0]      ser_valid;
  logic [1:0]      ser_last;
  logic [1:0]      busy;
  logic [1:0][2:0] sel;

  exp_t exp_q[2][$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc[2];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      serializer8_if bus ();

      serializer8 #(
        .MSB_FIRST  (gi == 1),
        .IDLE_LEVEL (gi == 0)
      ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
      );

      assign bus.in_data   = in_data[gi];
      assign bus.in_valid  = in_valid[gi];
      assign bus.ser_ready = ser_ready[gi];
      assign in_ready[gi]  = bus.in_ready;
      assign ser_out[gi]   = bus.ser_out;
      assign ser_valid[gi] = bus.ser_valid;
      assign ser_last[gi]  = bus.ser_last;
      assign busy[gi]      = bus.busy;
      assign sel[gi]       = bus.sel;

      initial begin : monitor
        exp_t e;
        logic idle_lvl;
        idle_lvl = (gi == 0);
        forever begin
          @(negedge clk);
          if (!rst) begin
            if (ser_valid[gi]) begin
              chk(busy[gi] === 1'b1, $sformatf("busy_shift%0d", gi), int'(busy[gi]), 1);
              chk(in_ready[gi] === (ser_last[gi] & ser_ready[gi]),
                  $sformatf("in_ready_shift%0d", gi), int'(in_ready[gi]),
                  int'(ser_last[gi] & ser_ready[gi]));
              if (ser_ready[gi]) begin
                if (exp_q[gi].size() == 0) begin
                  chk(1'b0, $sformatf("unexpected_bit%0d", gi), int'(ser_out[gi]), -1);
                end else begin
                  e = exp_q[gi].pop_front();
                  $display("dut%0d bit=%0d sel=%0d last=%0d", gi, ser_out[gi], sel[gi], ser_last[gi]);
                  chk(ser_out[gi] === e.b, $sformatf("ser_out%0d", gi), int'(ser_out[gi]), int'(e.b));
                  chk(sel[gi] === e.sel, $sformatf("sel%0d", gi), int'(sel[gi]), int'(e.sel));
                  chk(ser_last[gi] === e.last, $sformatf("ser_last%0d", gi), int'(ser_last[gi]), int'(e.last));
                end
              end
            end else begin
              chk(ser_out[gi] === idle_lvl, $sformatf("idle_out%0d", gi), int'(ser_out[gi]), int'(idle_lvl));
              chk(sel[gi] === 3'd0, $sformatf("idle_sel%0d", gi), int'(sel[gi]), 0);
              chk(busy[gi] === 1'b0, $sformatf("idle_busy%0d", gi), int'(busy[gi]), 0);
              chk(ser_last[gi] === 1'b0, $sformatf("idle_last%0d", gi), int'(ser_last[gi]), 0);
              chk(in_ready[gi] === 1'b1, $sformatf("idle_ready%0d", gi), int'(in_ready[gi]), 1);
            end
          end
        end
      end
    end
  endgenerate

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [7:0] w, input bit keep_valid, input bit mark);
    int k;
    bit got;
    logic [2:0] idx;
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    got = 1'b0;
    for (k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (in_ready[d]) got = 1'b1;
    end
    if (!got) begin
      chk(1'b0, "accept_timeout", 0, 1);
    end else begin
      if (mark) acc_cyc[d] = cyc + 1;
      for (int b = 0; b < 8; b++) begin
        idx = (d == 1) ? 3'(7 - b) : 3'(b);
        exp_q[d].push_back('{b: w[idx], sel: idx, last: (b == 7)});
      end
      $display("dut%0d accept word=%02h", d, w);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int span);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!ser_valid[d]) done = 1'b1;
    end
    chk(done, "idle_timeout", int'(done), 1);
    chk((cyc - acc_cyc[d]) == span, "word_span", cyc - acc_cyc[d], span);
    chk(exp_q[d].size() == 0, "queue_drained", exp_q[d].size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_data   = '0;
    in_valid  = '0;
    ser_ready = 2'b11;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(in_ready[d] === 1'b0, "rst_in_ready", int'(in_ready[d]), 0);
      chk(ser_valid[d] === 1'b0, "rst_ser_valid", int'(ser_valid[d]), 0);
      chk(busy[d] === 1'b0, "rst_busy", int'(busy[d]), 0);
      chk(sel[d] === 3'd0, "rst_sel", int'(sel[d]), 0);
      chk(ser_out[d] === (d == 0), "rst_ser_out", int'(ser_out[d]), int'(d == 0));
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk(in_ready[1] === 1'b1, "ready_after_rst", int'(in_ready[1]), 1);

    // MSB-first A5, then LSB-first 01
    send(1, 8'hA5, 1'b0, 1'b1);
    wait_idle(1, 8);
    send(0, 8'h01, 1'b0, 1'b1);
    wait_idle(0, 8);

    // F0 with a 3-cycle stall on the third bit (bit 5 = 1)
    send(1, 8'hF0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 ser_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(ser_out[1] === 1'b1, "stall_out", int'(ser_out[1]), 1);
      chk(sel[1] === 3'd5, "stall_sel", int'(sel[1]), 5);
      chk(ser_valid[1] === 1'b1, "stall_valid", int'(ser_valid[1]), 1);
    end
    @(posedge clk);
    #1 ser_ready[1] = 1'b1;
    wait_idle(1, 11);

    // Back-to-back C3, 3C with in_valid held high
    send(1, 8'hC3, 1'b1, 1'b1);
    send(1, 8'h3C, 1'b0, 1'b0);
    wait_idle(1, 16);

    // Asynchronous reset mid-word at cnt=4 of FF, then 80
    send(1, 8'hFF, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #3;
    chk(sel[1] === 3'd3, "pre_rst_sel", int'(sel[1]), 3);
    rst = 1'b1;
    #1;
    chk(ser_valid[1] === 1'b0, "async_rst_valid", int'(ser_valid[1]), 0);
    chk(busy[1] === 1'b0, "async_rst_busy", int'(busy[1]), 0);
    chk(sel[1] === 3'd0, "async_rst_sel", int'(sel[1]), 0);
    chk(in_ready[1] === 1'b0, "async_rst_ready", int'(in_ready[1]), 0);
    chk(ser_out[1] === 1'b0, "async_rst_out", int'(ser_out[1]), 0);
    exp_q[1].delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    send(1, 8'h80, 1'b0, 1'b1);
    wait_idle(1, 8);

    // in_valid high with toggling data while mid-word must be ignored
    send(1, 8'h5A, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      in_data[1] = (k % 2 == 0) ? 8'hFF : 8'h00;
      @(negedge clk);
      chk(in_ready[1] === 1'b0, "midword_ready", int'(in_ready[1]), 0);
      @(posedge clk);
      #1;
    end
    in_valid[1] = 1'b0;
    wait_idle(1, 8);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
